// File: rtl/atom_pkg.sv
// Shared constants and state encoding for the SPI boot loader.
package atom_pkg;

   localparam int          DEF_ADDR_W          = 18;
   localparam int unsigned DEF_BOOT_START_ADDR = 32'h0_C000;
   localparam int unsigned DEF_BOOT_END_ADDR   = 32'h0_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RECV = 2'd1,
      ST_DONE = 2'd2
   } boot_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for an asynchronous SPI pin with rising-edge detect.
// The level is taken from stage 2 so it lines up with the edge pulse.
module spi_sync_edge (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_async,
   output logic o_sync,
   output logic o_rise
);

   logic [2:0] r_sync;

   // Shift the pin through the chain; reset to the idle-high level of the SPI pins.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) r_sync <= 3'b111;
      else       r_sync <= {r_sync[1:0], i_async};
   end

   assign o_sync = r_sync[1];
   assign o_rise = r_sync[1] & ~r_sync[2];

endmodule

// File: rtl/spi_boot_loader.sv
// Receives the boot image over SPI and turns each byte into an SRAM write
// request, holding the CPU in reset until the whole image has been written.
module spi_boot_loader
   import atom_pkg::*;
#(
   parameter int                ADDR_W          = DEF_ADDR_W,
   parameter logic [ADDR_W-1:0] BOOT_START_ADDR = ADDR_W'(DEF_BOOT_START_ADDR),
   parameter logic [ADDR_W-1:0] BOOT_END_ADDR   = ADDR_W'(DEF_BOOT_END_ADDR)
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_arm_ss,
   input  logic              i_arm_sclk,
   input  logic              i_arm_mosi,
   output logic              o_booting,
   output logic              o_mem_req,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [7:0]        o_mem_data,
   input  logic              i_mem_ack,
   output logic              o_overrun
);

   localparam logic [ADDR_W-1:0] LAST_P1 = BOOT_END_ADDR + ADDR_W'(1);

   boot_state_t       r_state, w_state_nxt;
   logic [6:0]        r_shift;
   logic [2:0]        r_bit_cnt;
   logic [1:0]        r_mosi_sync;
   logic              r_mem_req, r_overrun, r_full, r_wait_ack;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [7:0]        r_mem_data;

   logic w_ss, w_ss_rise, w_sclk, w_sclk_rise;
   logic w_bit_en, w_byte_done, w_accept, w_drop, w_ack, w_req_nxt;
   logic w_last, w_img_end, w_ss_end, w_wait_set, w_abort;
   logic [7:0] w_byte;

   spi_sync_edge u_sync_ss (
      .i_clk(i_clk), .i_rst(i_reset), .i_async(i_arm_ss),
      .o_sync(w_ss), .o_rise(w_ss_rise)
   );

   spi_sync_edge u_sync_sclk (
      .i_clk(i_clk), .i_rst(i_reset), .i_async(i_arm_sclk),
      .o_sync(w_sclk), .o_rise(w_sclk_rise)
   );

   // mosi only needs two stages: stage 2 has the same latency as the sclk edge pulse.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_mosi_sync <= 2'b11;
      else         r_mosi_sync <= {r_mosi_sync[0], i_arm_mosi};
   end

   assign w_bit_en    = (r_state == ST_RECV) & ~r_wait_ack & w_sclk_rise;
   assign w_byte_done = w_bit_en & (r_bit_cnt == 3'd7);
   assign w_byte      = {r_shift, r_mosi_sync[1]};
   assign w_ack       = r_mem_req & i_mem_ack;
   // Bytes past the end of the image (r_full) are silently discarded.
   assign w_accept    = w_byte_done & ~r_full & ~r_mem_req;
   assign w_drop      = w_byte_done & ~r_full &  r_mem_req;
   assign w_req_nxt   = w_accept | (r_mem_req & ~i_mem_ack);
   assign w_last      = (r_mem_addr == BOOT_END_ADDR);
   // Image counts as complete once the final write has landed or is in flight.
   assign w_img_end   = r_full | (w_ack & w_last) | (w_req_nxt & w_last);
   assign w_ss_end    = (r_state == ST_RECV) & ~r_wait_ack & w_ss_rise;

   // State register.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Next state: a byte finishing in the same cycle as ss rise is already
   // folded into w_req_nxt / w_img_end, so it is accepted before ss is handled.
   always_comb begin
      w_state_nxt = r_state;
      w_wait_set  = 1'b0;
      w_abort     = 1'b0;
      case (r_state)
         // Enter a frame only with sclk parked high so a half-seen edge is not taken as bit 0.
         ST_IDLE: if (!w_ss && w_sclk) w_state_nxt = ST_RECV;
         ST_RECV: begin
            if (r_wait_ack) begin
               if (!r_mem_req) w_state_nxt = ST_DONE;
            end else if (w_ss_end) begin
               if (w_img_end) begin
                  if (w_req_nxt) w_wait_set  = 1'b1;
                  else           w_state_nxt = ST_DONE;
               end else begin
                  w_abort     = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         ST_DONE: w_state_nxt = ST_DONE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Shift register, write handshake, address counter and status flags.
   // An aborted frame also cancels any pending write, as the image restarts.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_shift    <= '0;
         r_bit_cnt  <= '0;
         r_mem_req  <= 1'b0;
         r_mem_addr <= BOOT_START_ADDR;
         r_mem_data <= '0;
         r_overrun  <= 1'b0;
         r_full     <= 1'b0;
         r_wait_ack <= 1'b0;
      end else begin
         r_mem_req <= w_req_nxt;
         if (w_bit_en) begin
            r_shift   <= w_byte[6:0];
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         if (w_ss_end)   r_bit_cnt  <= '0;
         if (w_accept)   r_mem_data <= w_byte;
         if (w_drop)     r_overrun  <= 1'b1;
         if (w_ack) begin
            if (r_mem_addr != LAST_P1) r_mem_addr <= r_mem_addr + ADDR_W'(1);
            if (w_last)                r_full     <= 1'b1;
         end
         if (w_wait_set) r_wait_ack <= 1'b1;
         if (w_abort) begin
            r_mem_addr <= BOOT_START_ADDR;
            r_mem_req  <= 1'b0;
            r_full     <= 1'b0;
         end
      end
   end

   assign o_booting  = (r_state != ST_DONE);
   assign o_mem_req  = r_mem_req;
   assign o_mem_addr = r_mem_addr;
   assign o_mem_data = r_mem_data;
   assign o_overrun  = r_overrun;

endmodule
